// File: rtl/alu_issue_queue_if.sv
// ============================================================================
// alu_issue_queue_if : dispatch and issue handshake bundle for alu_issue_queue
// Rev 1.0
// ============================================================================
`default_nettype none

interface alu_issue_queue_if #(
  parameter int TAG_W = 5
);
  logic             disp_valid_i;
  logic             disp_ready_o;
  logic [31:0]      disp_pc_i;
  logic [31:0]      disp_inst_i;
  logic [TAG_W-1:0] disp_prs1_i;
  logic             disp_prs1_rdy_i;
  logic [TAG_W-1:0] disp_prs2_i;
  logic             disp_prs2_rdy_i;
  logic [TAG_W-1:0] disp_prd_i;

  logic             issue_valid_o;
  logic             issue_ready_i;
  logic [31:0]      issue_pc_o;
  logic [31:0]      issue_inst_o;
  logic [TAG_W-1:0] issue_prs1_o;
  logic [TAG_W-1:0] issue_prs2_o;
  logic [TAG_W-1:0] issue_prd_o;

  // Rename and ALU side
  modport master (
    output disp_valid_i, disp_pc_i, disp_inst_i, disp_prs1_i, disp_prs1_rdy_i,
           disp_prs2_i, disp_prs2_rdy_i, disp_prd_i, issue_ready_i,
    input  disp_ready_o, issue_valid_o, issue_pc_o, issue_inst_o,
           issue_prs1_o, issue_prs2_o, issue_prd_o
  );

  // Queue side
  modport slave (
    input  disp_valid_i, disp_pc_i, disp_inst_i, disp_prs1_i, disp_prs1_rdy_i,
           disp_prs2_i, disp_prs2_rdy_i, disp_prd_i, issue_ready_i,
    output disp_ready_o, issue_valid_o, issue_pc_o, issue_inst_o,
           issue_prs1_o, issue_prs2_o, issue_prd_o
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue_queue.sv
// ============================================================================
// alu_issue_queue : collapsing ALU reservation station with CDB wakeup
//   optional macro ISSUE_WAKEUP_BYPASS_EN : select sees same-cycle CDB wakeups
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5,
  parameter int CNT_W = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              cdb_en_i,
  input  logic [TAG_W-1:0]  cdb_reg_addr_i,
  alu_issue_queue_if.slave  q_if,
  output logic [CNT_W-1:0]  count_o
);

`ifdef ISSUE_WAKEUP_BYPASS_EN
  localparam bit c_BYPASS_EN = 1'b1;
`else
  localparam bit c_BYPASS_EN = 1'b0;
`endif
  localparam int c_IDX_W = $clog2(DEPTH);

  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [TAG_W-1:0] prs1_q [DEPTH];
  logic [TAG_W-1:0] prs2_q [DEPTH];
  logic [TAG_W-1:0] prd_q  [DEPTH];
  logic             r1_q   [DEPTH];
  logic             r2_q   [DEPTH];
  logic [31:0]      pc_d   [DEPTH];
  logic [31:0]      inst_d [DEPTH];
  logic [TAG_W-1:0] prs1_d [DEPTH];
  logic [TAG_W-1:0] prs2_d [DEPTH];
  logic [TAG_W-1:0] prd_d  [DEPTH];
  logic             r1_d   [DEPTH];
  logic             r2_d   [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  logic [CNT_W-1:0]   w_cnt_after;
  logic               w_sel_found;
  logic [c_IDX_W-1:0] w_sel_idx;
  logic               w_issue_valid, w_issue_fire;
  logic               w_disp_ready, w_disp_fire;

  function automatic logic src_ready(input logic r, input logic [TAG_W-1:0] tag,
                                     input logic cdb_en, input logic [TAG_W-1:0] cdb_tag);
    return r | (c_BYPASS_EN & cdb_en & (tag == cdb_tag));
  endfunction

  // Occupied slots are always 0..count_q-1, so validity is derived from the count.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i < int'(count_q) &&
          src_ready(r1_q[i], prs1_q[i], cdb_en_i, cdb_reg_addr_i) &&
          src_ready(r2_q[i], prs2_q[i], cdb_en_i, cdb_reg_addr_i)) begin
        w_sel_found = 1'b1;
        w_sel_idx   = c_IDX_W'(i);
      end
    end
  end

  assign w_issue_valid = w_sel_found & ~flush_i;
  assign w_issue_fire  = w_issue_valid & q_if.issue_ready_i;
  assign w_disp_ready  = (count_q != CNT_W'(DEPTH));
  assign w_disp_fire   = q_if.disp_valid_i & w_disp_ready & ~flush_i;

  assign q_if.disp_ready_o  = w_disp_ready;
  assign q_if.issue_valid_o = w_issue_valid;
  assign q_if.issue_pc_o    = w_issue_valid ? pc_q[w_sel_idx]   : '0;
  assign q_if.issue_inst_o  = w_issue_valid ? inst_q[w_sel_idx] : '0;
  assign q_if.issue_prs1_o  = w_issue_valid ? prs1_q[w_sel_idx] : '0;
  assign q_if.issue_prs2_o  = w_issue_valid ? prs2_q[w_sel_idx] : '0;
  assign q_if.issue_prd_o   = w_issue_valid ? prd_q[w_sel_idx]  : '0;
  assign count_o            = count_q;

  always_comb begin
    w_cnt_after = count_q - {{(CNT_W-1){1'b0}}, w_issue_fire};
    count_d     = flush_i ? '0 : (w_cnt_after + {{(CNT_W-1){1'b0}}, w_disp_fire});
    for (int i = 0; i < DEPTH; i++) begin
      int src;
      src = i;
      // Entries younger than the issued one collapse down by one slot.
      if (w_issue_fire && i >= int'(w_sel_idx) && i < DEPTH - 1) src = i + 1;
      pc_d[i]   = pc_q[src];
      inst_d[i] = inst_q[src];
      prs1_d[i] = prs1_q[src];
      prs2_d[i] = prs2_q[src];
      prd_d[i]  = prd_q[src];
      r1_d[i]   = r1_q[src] | (cdb_en_i && prs1_q[src] == cdb_reg_addr_i);
      r2_d[i]   = r2_q[src] | (cdb_en_i && prs2_q[src] == cdb_reg_addr_i);
      if (w_disp_fire && i == int'(w_cnt_after)) begin
        pc_d[i]   = q_if.disp_pc_i;
        inst_d[i] = q_if.disp_inst_i;
        prs1_d[i] = q_if.disp_prs1_i;
        prs2_d[i] = q_if.disp_prs2_i;
        prd_d[i]  = q_if.disp_prd_i;
        r1_d[i]   = q_if.disp_prs1_rdy_i | (q_if.disp_prs1_i == '0) |
                    (cdb_en_i && q_if.disp_prs1_i == cdb_reg_addr_i);
        r2_d[i]   = q_if.disp_prs2_rdy_i | (q_if.disp_prs2_i == '0) |
                    (cdb_en_i && q_if.disp_prs2_i == cdb_reg_addr_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  // Payload needs no reset: slots at or above count_q are never observed.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      pc_q[i]   <= pc_d[i];
      inst_q[i] <= inst_d[i];
      prs1_q[i] <= prs1_d[i];
      prs2_q[i] <= prs2_d[i];
      prd_q[i]  <= prd_d[i];
      r1_q[i]   <= r1_d[i];
      r2_q[i]   <= r2_d[i];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
// ============================================================================
// tb_alu_issue_queue : directed self-checking bench for alu_issue_queue
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int CNT_W = 3;

  logic             clk_i = 1'b0;
  logic             reset_i, flush_i, cdb_en_i;
  logic [TAG_W-1:0] cdb_reg_addr_i;
  logic [CNT_W-1:0] count_o;
  int               n_checks = 0;
  int               n_fail   = 0;

  alu_issue_queue_if #(.TAG_W(TAG_W)) q_if ();

  alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .flush_i        (flush_i),
    .cdb_en_i       (cdb_en_i),
    .cdb_reg_addr_i (cdb_reg_addr_i),
    .q_if           (q_if),
    .count_o        (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    q_if.disp_valid_i    = 1'b0;
    q_if.disp_pc_i       = '0;
    q_if.disp_inst_i     = '0;
    q_if.disp_prs1_i     = '0;
    q_if.disp_prs1_rdy_i = 1'b0;
    q_if.disp_prs2_i     = '0;
    q_if.disp_prs2_rdy_i = 1'b0;
    q_if.disp_prd_i      = '0;
    cdb_en_i             = 1'b0;
    cdb_reg_addr_i       = '0;
    flush_i              = 1'b0;
  endtask

  task automatic set_disp(input logic [31:0] pc, input logic [TAG_W-1:0] p1, input logic r1,
                          input logic [TAG_W-1:0] p2, input logic r2, input logic [TAG_W-1:0] pd);
    q_if.disp_valid_i    = 1'b1;
    q_if.disp_pc_i       = pc;
    q_if.disp_inst_i     = pc ^ 32'hA5A5_0000;
    q_if.disp_prs1_i     = p1;
    q_if.disp_prs1_rdy_i = r1;
    q_if.disp_prs2_i     = p2;
    q_if.disp_prs2_rdy_i = r2;
    q_if.disp_prd_i      = pd;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    idle();
    q_if.issue_ready_i = 1'b0;
    step(); step();
    reset_i = 1'b0;
    settle();
    n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    n_checks++; if (q_if.disp_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", q_if.disp_ready_o); end
    n_checks++; if (q_if.issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_issue_valid: got %b expected 0", q_if.issue_valid_o); end
    n_checks++;
    if ({q_if.issue_pc_o, q_if.issue_inst_o, q_if.issue_prs1_o, q_if.issue_prs2_o, q_if.issue_prd_o} !== '0) begin
      n_fail++; $display("FAIL reset_issue_data: got pc=%h inst=%h expected all 0", q_if.issue_pc_o, q_if.issue_inst_o);
    end
  endtask

  task automatic test_single();
    q_if.issue_ready_i = 1'b1;
    set_disp(32'h100, 5'd3, 1'b1, 5'd0, 1'b1, 5'd4);
    settle();
    n_checks++; if (q_if.issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_latency: got %b expected 0", q_if.issue_valid_o); end
    step(); idle(); settle();
    n_checks++; if (q_if.issue_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", q_if.issue_valid_o); end
    n_checks++; if (q_if.issue_pc_o !== 32'h100) begin n_fail++; $display("FAIL single_pc: got %h expected 100", q_if.issue_pc_o); end
    n_checks++; if (q_if.issue_inst_o !== 32'hA5A5_0100) begin n_fail++; $display("FAIL single_inst: got %h expected a5a50100", q_if.issue_inst_o); end
    n_checks++; if ({q_if.issue_prs1_o, q_if.issue_prd_o} !== {5'd3, 5'd4}) begin n_fail++; $display("FAIL single_tags: got %0d/%0d expected 3/4", q_if.issue_prs1_o, q_if.issue_prd_o); end
    n_checks++; if (count_o !== 3'd1) begin n_fail++; $display("FAIL single_count1: got %0d expected 1", count_o); end
    step(); settle();
    n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL single_count0: got %0d expected 0", count_o); end
  endtask

  task automatic test_order();
    q_if.issue_ready_i = 1'b1;
    set_disp(32'h200, 5'd7, 1'b0, 5'd0, 1'b0, 5'd20);
    step();
    set_disp(32'h204, 5'd1, 1'b1, 5'd2, 1'b1, 5'd21);
    settle();
    n_checks++; if (q_if.issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL order_a_blocked: got %b expected 0", q_if.issue_valid_o); end
    step(); idle(); settle();
    n_checks++; if (q_if.issue_pc_o !== 32'h204 || q_if.issue_valid_o !== 1'b1) begin n_fail++; $display("FAIL order_b_first: got v=%b pc=%h expected v=1 pc=204", q_if.issue_valid_o, q_if.issue_pc_o); end
    step(); settle();
    n_checks++; if (count_o !== 3'd1 || q_if.issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL order_a_waiting: got cnt=%0d v=%b expected cnt=1 v=0", count_o, q_if.issue_valid_o); end
    cdb_en_i = 1'b1; cdb_reg_addr_i = 5'd7;
    settle();
`ifdef ISSUE_WAKEUP_BYPASS_EN
    n_checks++; if (q_if.issue_valid_o !== 1'b1 || q_if.issue_pc_o !== 32'h200) begin n_fail++; $display("FAIL order_wake_n: got v=%b pc=%h expected v=1 pc=200", q_if.issue_valid_o, q_if.issue_pc_o); end
`else
    n_checks++; if (q_if.issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL order_wake_n: got v=%b expected 0", q_if.issue_valid_o); end
`endif
    step(); idle(); settle();
`ifdef ISSUE_WAKEUP_BYPASS_EN
    n_checks++; if (q_if.issue_valid_o !== 1'b0 || count_o !== 3'd0) begin n_fail++; $display("FAIL order_wake_n1: got v=%b cnt=%0d expected v=0 cnt=0", q_if.issue_valid_o, count_o); end
`else
    n_checks++; if (q_if.issue_valid_o !== 1'b1 || q_if.issue_pc_o !== 32'h200) begin n_fail++; $display("FAIL order_wake_n1: got v=%b pc=%h expected v=1 pc=200", q_if.issue_valid_o, q_if.issue_pc_o); end
`endif
    step(); settle();
    n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL order_drain: got %0d expected 0", count_o); end
  endtask

  task automatic test_full();
    q_if.issue_ready_i = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      set_disp(32'h300 + 32'(4 * k), 5'd9, 1'b0, 5'd0, 1'b0, 5'(k + 1));
      step();
    end
    set_disp(32'h3F0, 5'd1, 1'b1, 5'd1, 1'b1, 5'd30);
    settle();
    n_checks++; if (count_o !== 3'd4 || q_if.disp_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_state: got cnt=%0d rdy=%b expected cnt=4 rdy=0", count_o, q_if.disp_ready_o); end
    step(); settle();
    n_checks++; if (count_o !== 3'd4 || q_if.issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_hold: got cnt=%0d v=%b expected cnt=4 v=0", count_o, q_if.issue_valid_o); end
    cdb_en_i = 1'b1; cdb_reg_addr_i = 5'd9;
    step();
    cdb_en_i = 1'b0;
    settle();
    n_checks++; if (q_if.issue_valid_o !== 1'b1 || q_if.issue_pc_o !== 32'h300) begin n_fail++; $display("FAIL full_first: got v=%b pc=%h expected v=1 pc=300", q_if.issue_valid_o, q_if.issue_pc_o); end
    step(); idle(); settle();
    for (int k = 1; k < DEPTH; k++) begin
      n_checks++;
      if (q_if.issue_pc_o !== 32'h300 + 32'(4 * k) || count_o !== 3'(DEPTH - k)) begin
        n_fail++; $display("FAIL full_drain%0d: got pc=%h cnt=%0d expected pc=%h cnt=%0d", k, q_if.issue_pc_o, count_o, 32'h300 + 32'(4 * k), DEPTH - k);
      end
      step();
    end
    n_checks++; if (count_o !== 3'd0 || q_if.issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_empty: got cnt=%0d v=%b expected 0/0", count_o, q_if.issue_valid_o); end
  endtask

  task automatic test_disp_bypass();
    q_if.issue_ready_i = 1'b1;
    set_disp(32'h500, 5'd0, 1'b1, 5'd5, 1'b0, 5'd6);
    cdb_en_i = 1'b1; cdb_reg_addr_i = 5'd5;
    step(); idle(); settle();
    n_checks++; if (q_if.issue_valid_o !== 1'b1 || q_if.issue_pc_o !== 32'h500 || q_if.issue_prs2_o !== 5'd5) begin
      n_fail++; $display("FAIL disp_bypass: got v=%b pc=%h prs2=%0d expected v=1 pc=500 prs2=5", q_if.issue_valid_o, q_if.issue_pc_o, q_if.issue_prs2_o);
    end
    step(); settle();
    n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL disp_bypass_drain: got %0d expected 0", count_o); end
  endtask

  task automatic test_back_to_back();
    q_if.issue_ready_i = 1'b1;
    set_disp(32'h600, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3);
    step();
    set_disp(32'h604, 5'd4, 1'b1, 5'd5, 1'b1, 5'd6);
    settle();
    n_checks++; if (q_if.issue_pc_o !== 32'h600 || count_o !== 3'd1) begin n_fail++; $display("FAIL b2b_first: got pc=%h cnt=%0d expected pc=600 cnt=1", q_if.issue_pc_o, count_o); end
    step(); idle(); settle();
    n_checks++; if (q_if.issue_pc_o !== 32'h604 || count_o !== 3'd1) begin n_fail++; $display("FAIL b2b_second: got pc=%h cnt=%0d expected pc=604 cnt=1", q_if.issue_pc_o, count_o); end
    step(); settle();
    n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL b2b_drain: got %0d expected 0", count_o); end
  endtask

  task automatic test_wake_shift();
    q_if.issue_ready_i = 1'b0;
    set_disp(32'h700, 5'd1, 1'b1, 5'd1, 1'b1, 5'd2);
    step();
    set_disp(32'h704, 5'd11, 1'b0, 5'd0, 1'b0, 5'd3);
    step(); idle();
    q_if.issue_ready_i = 1'b1;
    cdb_en_i = 1'b1; cdb_reg_addr_i = 5'd11;
    settle();
    n_checks++; if (q_if.issue_pc_o !== 32'h700 || count_o !== 3'd2) begin n_fail++; $display("FAIL wshift_older: got pc=%h cnt=%0d expected pc=700 cnt=2", q_if.issue_pc_o, count_o); end
    step(); cdb_en_i = 1'b0; settle();
    n_checks++; if (q_if.issue_valid_o !== 1'b1 || q_if.issue_pc_o !== 32'h704 || count_o !== 3'd1) begin
      n_fail++; $display("FAIL wshift_younger: got v=%b pc=%h cnt=%0d expected v=1 pc=704 cnt=1", q_if.issue_valid_o, q_if.issue_pc_o, count_o);
    end
    step(); settle();
    n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL wshift_drain: got %0d expected 0", count_o); end
  endtask

  task automatic test_flush();
    q_if.issue_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_disp(32'h800 + 32'(4 * k), 5'd1, 1'b1, 5'd1, 1'b1, 5'(k));
      step();
    end
    idle(); settle();
    n_checks++; if (count_o !== 3'd3 || q_if.issue_pc_o !== 32'h800) begin n_fail++; $display("FAIL flush_pre: got cnt=%0d pc=%h expected cnt=3 pc=800", count_o, q_if.issue_pc_o); end
    flush_i = 1'b1;
    set_disp(32'h8F0, 5'd1, 1'b1, 5'd1, 1'b1, 5'd9);
    settle();
    n_checks++; if (q_if.issue_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", q_if.issue_valid_o); end
    step(); idle(); settle();
    n_checks++; if (count_o !== 3'd0 || q_if.disp_ready_o !== 1'b1 || q_if.issue_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_after: got cnt=%0d rdy=%b v=%b expected 0/1/0", count_o, q_if.disp_ready_o, q_if.issue_valid_o);
    end
    step(); settle();
    n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL flush_dropped: got %0d expected 0", count_o); end
  endtask

  task automatic test_stall();
    q_if.issue_ready_i = 1'b0;
    set_disp(32'h900, 5'd12, 1'b1, 5'd13, 1'b1, 5'd14);
    q_if.disp_inst_i = 32'hDEAD_BEEF;
    step(); idle(); settle();
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({q_if.issue_valid_o, q_if.issue_pc_o, q_if.issue_inst_o, q_if.issue_prs1_o, q_if.issue_prs2_o, q_if.issue_prd_o}
          !== {1'b1, 32'h900, 32'hDEAD_BEEF, 5'd12, 5'd13, 5'd14}) begin
        n_fail++; $display("FAIL stall_cycle%0d: got v=%b pc=%h inst=%h prd=%0d expected v=1 pc=900 inst=deadbeef prd=14",
                           c, q_if.issue_valid_o, q_if.issue_pc_o, q_if.issue_inst_o, q_if.issue_prd_o);
      end
      step();
    end
    q_if.issue_ready_i = 1'b1;
    step(); settle();
    n_checks++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL stall_release: got %0d expected 0", count_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_full();
    test_disp_bypass();
    test_back_to_back();
    test_wake_shift();
    test_flush();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
